// File: rtl/isa_pkg.sv
// Shared ISA constants: base opcodes, 4-bit Opsel ALU codes (same encoding the
// control unit decodes) and the loader FSM state type.
package isa_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SGT  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLA  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_MOV  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FIN    = 2'd3
  } load_state_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus of the program loader.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the requester holds all req_* fields stable while
// req_valid is high and may not drop req_valid before the transfer.
// imem_we is a single-cycle write strobe qualifying imem_addr/imem_wdata.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_opsel;
  logic              req_is_imm;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [11:0]       req_imm;
  logic              req_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_opsel, req_is_imm, req_rd, req_rs1, req_rs2,
           req_imm, req_last,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_opsel, req_is_imm, req_rd, req_rs1, req_rs2,
           req_imm, req_last,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_field_encoder.sv
// Combinational Opsel -> (funct7, funct3) map and R/I-type word assembly.
// valid_enc is 0 when the Opsel has no encoding for the requested format.
module instr_field_encoder
  import isa_pkg::*;
(
  input  logic [3:0]  opsel,
  input  logic        is_imm,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        valid_enc
);

  logic [6:0] funct7;
  logic [2:0] funct3;

  // Field lookup; I-type has its own smaller funct3 map and no funct7.
  always_comb begin
    funct7    = 7'd0;
    funct3    = 3'd0;
    valid_enc = 1'b1;
    if (is_imm) begin
      case (opsel)
        OP_ADD:  funct3 = 3'd0;
        OP_SLT:  funct3 = 3'd1;
        OP_AND:  funct3 = 3'd2;
        OP_OR:   funct3 = 3'd3;
        OP_XOR:  funct3 = 3'd4;
        OP_SLL:  funct3 = 3'd5;
        OP_SRL:  funct3 = 3'd6;
        OP_SRA:  funct3 = 3'd7;
        default: valid_enc = 1'b0;
      endcase
    end else begin
      case (opsel)
        OP_ADD:  begin funct7 = 7'd0; funct3 = 3'd0; end
        OP_SUB:  begin funct7 = 7'd0; funct3 = 3'd1; end
        OP_MUL:  begin funct7 = 7'd0; funct3 = 3'd2; end
        OP_SLL:  begin funct7 = 7'd1; funct3 = 3'd0; end
        OP_SRL:  begin funct7 = 7'd1; funct3 = 3'd1; end
        OP_SLA:  begin funct7 = 7'd1; funct3 = 3'd2; end
        OP_SRA:  begin funct7 = 7'd1; funct3 = 3'd3; end
        OP_SLT:  begin funct7 = 7'd2; funct3 = 3'd0; end
        OP_SGT:  begin funct7 = 7'd2; funct3 = 3'd1; end
        OP_XOR:  begin funct7 = 7'd3; funct3 = 3'd0; end
        OP_AND:  begin funct7 = 7'd3; funct3 = 3'd1; end
        OP_OR:   begin funct7 = 7'd3; funct3 = 3'd2; end
        OP_NAND: begin funct7 = 7'd3; funct3 = 3'd3; end
        OP_NOR:  begin funct7 = 7'd3; funct3 = 3'd4; end
        default: valid_enc = 1'b0;
      endcase
    end
  end

  assign word = is_imm ? {imm, rs1, funct3, rd, OPC_ITYPE}
                       : {funct7, rs2, rs1, funct3, rd, OPC_RTYPE};

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes Opsel requests into R/I-type words and writes them
// to consecutive instruction-memory addresses starting at 0 for each session.
// A session ends on req_last or when the last address has been written.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  instr_encoder_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W:0]      word_count,
  output load_state_t          state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  load_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       word_q;
  logic              last_q;
  logic              err_q;
  logic [31:0]       enc_word;
  logic              enc_ok;
  logic              fire;

  instr_field_encoder u_enc (
    .opsel     (bus.req_opsel),
    .is_imm    (bus.req_is_imm),
    .rd        (bus.req_rd),
    .rs1       (bus.req_rs1),
    .rs2       (bus.req_rs2),
    .imm       (bus.req_imm),
    .word      (enc_word),
    .valid_enc (enc_ok)
  );

  assign fire = bus.req_valid && (state_q == ST_ACCEPT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: unencodable requests stay in ACCEPT unless they carry req_last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACCEPT;
      ST_ACCEPT: begin
        if (fire) begin
          if (enc_ok)                 state_d = ST_WRITE;
          else if (bus.req_last)      state_d = ST_FIN;
        end
      end
      ST_WRITE:  state_d = (last_q || addr_q == LAST_ADDR) ? ST_FIN : ST_ACCEPT;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Session datapath: address/count, captured word, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (fire) begin
            if (enc_ok) begin
              word_q <= enc_word;
              last_q <= bus.req_last;
            end else begin
              err_q  <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          addr_q  <= addr_q + 1'b1;
          count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == ST_ACCEPT);
  assign bus.imem_we    = (state_q == ST_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word_q;
  assign busy           = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
  assign done           = (state_q == ST_FIN);
  assign err            = err_q;
  assign word_count     = count_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a DEPTH=64 and a DEPTH=4 instance share one
// request driver; sel chooses which instance is active.
module tb_instr_encoder_loader;
  import isa_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        sel;
  logic        start;
  logic        v;
  logic [3:0]  opsel;
  logic        is_imm;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm;
  logic        last;

  instr_encoder_loader_if #(.ADDR_W(6)) bus_a ();
  instr_encoder_loader_if #(.ADDR_W(2)) bus_s ();

  assign bus_a.req_valid = v & ~sel;  assign bus_s.req_valid = v & sel;
  assign bus_a.req_opsel = opsel;     assign bus_s.req_opsel = opsel;
  assign bus_a.req_is_imm = is_imm;   assign bus_s.req_is_imm = is_imm;
  assign bus_a.req_rd = rd;           assign bus_s.req_rd = rd;
  assign bus_a.req_rs1 = rs1;         assign bus_s.req_rs1 = rs1;
  assign bus_a.req_rs2 = rs2;         assign bus_s.req_rs2 = rs2;
  assign bus_a.req_imm = imm;         assign bus_s.req_imm = imm;
  assign bus_a.req_last = last;       assign bus_s.req_last = last;

  logic        busy_a, done_a, err_a, busy_s, done_s, err_s;
  logic [6:0]  cnt_a;
  logic [2:0]  cnt_s;
  load_state_t st_a, st_s;

  instr_encoder_loader #(.DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .bus(bus_a),
    .busy(busy_a), .done(done_a), .err(err_a), .word_count(cnt_a),
    .state_dbg(st_a)
  );

  instr_encoder_loader #(.DEPTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .bus(bus_s),
    .busy(busy_s), .done(done_s), .err(err_s), .word_count(cnt_s),
    .state_dbg(st_s)
  );

  // Observed signals of the selected instance.
  logic        m_ready, m_we, m_busy, m_done, m_err;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata;
  logic [6:0]  m_cnt;
  assign m_ready = sel ? bus_s.req_ready : bus_a.req_ready;
  assign m_we    = sel ? bus_s.imem_we : bus_a.imem_we;
  assign m_addr  = sel ? {4'b0, bus_s.imem_addr} : bus_a.imem_addr;
  assign m_wdata = sel ? bus_s.imem_wdata : bus_a.imem_wdata;
  assign m_busy  = sel ? busy_s : busy_a;
  assign m_done  = sel ? done_s : done_a;
  assign m_err   = sel ? err_s : err_a;
  assign m_cnt   = sel ? {4'b0, cnt_s} : cnt_a;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [37:0] exp_q[$];  // {addr, word}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Encoding tables indexed by Opsel, filled from the mnemonic list.
  bit r_ok[16];
  int r_f7[16];
  int r_f3[16];
  bit i_ok[16];
  int i_f3[16];
  int addr_m, cnt_m, depth_m;
  bit err_m, active_m;

  task automatic set_r(input int op, input int f7, input int f3);
    r_ok[op] = 1'b1; r_f7[op] = f7; r_f3[op] = f3;
  endtask

  task automatic set_i(input int op, input int f3);
    i_ok[op] = 1'b1; i_f3[op] = f3;
  endtask

  function automatic logic [31:0] model_word(input logic [3:0] op, input logic imf,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im);
    logic [31:0] w;
    if (imf)
      w = (32'(im) << 20) + (32'(s1) << 15) + (32'(i_f3[op]) << 12) + (32'(d) << 7) + 32'h13;
    else
      w = (32'(r_f7[op]) << 25) + (32'(s2) << 20) + (32'(s1) << 15)
        + (32'(r_f3[op]) << 12) + (32'(d) << 7) + 32'h33;
    return w;
  endfunction

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    #1;
    if (rst_n && m_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", 64'(m_addr), 64'hFFFF);
      else chk("imem_write", {m_addr, m_wdata}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    addr_m = 0; cnt_m = 0; err_m = 1'b0; active_m = 1'b1;
    chk("start_ready", m_ready, 1);
    chk("start_busy", m_busy, 1);
    chk("start_count", m_cnt, 0);
    chk("start_err", m_err, 0);
  endtask

  task automatic send(input logic [3:0] op, input logic imf, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im, input logic lst);
    bit ok;
    bit ended;
    int n;
    ok = imf ? i_ok[op] : r_ok[op];
    opsel = op; is_imm = imf; rd = d; rs1 = s1; rs2 = s2; imm = im; last = lst;
    v = 1'b1;
    if (!active_m) begin
      repeat (4) begin
        chk("ready_low_after_end", m_ready, 0);
        @(negedge clk);
      end
      v = 1'b0;
      return;
    end
    n = 0;
    while (!m_ready && n < 10) begin @(negedge clk); n++; end
    if (!m_ready) begin
      chk("ready_timeout", 0, 1);
      v = 1'b0;
      return;
    end
    @(negedge clk);
    v = 1'b0;
    if (ok) begin
      exp_q.push_back({6'(addr_m), model_word(op, imf, d, s1, s2, im)});
      chk("we_in_write", m_we, 1);
      ended = lst || (addr_m == depth_m - 1);
      addr_m++; cnt_m++;
      if (ended) @(negedge clk);
    end else begin
      err_m = 1'b1;
      chk("bad_no_write", m_we, 0);
      chk("bad_err_set", m_err, 1);
      chk("bad_addr_hold", m_addr, 64'(addr_m));
      ended = lst;
    end
    if (ended) begin
      chk("fin_done", m_done, 1);
      chk("fin_busy", m_busy, 0);
      chk("fin_count", m_cnt, 64'(cnt_m));
      chk("fin_err", m_err, 64'(err_m));
      @(negedge clk);
      chk("idle_done_low", m_done, 0);
      chk("idle_ready_low", m_ready, 0);
      active_m = 1'b0;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    set_r(0, 0, 0); set_r(1, 0, 1); set_r(13, 0, 2);
    set_r(2, 1, 0); set_r(3, 1, 1); set_r(7, 1, 2); set_r(8, 1, 3);
    set_r(4, 2, 0); set_r(5, 2, 1);
    set_r(6, 3, 0); set_r(9, 3, 1); set_r(10, 3, 2); set_r(11, 3, 3); set_r(12, 3, 4);
    set_i(0, 0); set_i(4, 1); set_i(9, 2); set_i(10, 3);
    set_i(6, 4); set_i(2, 5); set_i(3, 6); set_i(8, 7);

    sel = 1'b0; depth_m = 64; start = 1'b0; v = 1'b0;
    opsel = '0; is_imm = 1'b0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; last = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", m_ready, 0);
    chk("rst_we", m_we, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_err", m_err, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_count", m_cnt, 0);
    chk("rst_state", st_a, ST_IDLE);
    rst_n = 1'b1;

    // R-type session: ADD, SUB, NOR(last)
    do_start();
    send(OP_ADD, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
    @(negedge clk);
    chk("count_after_first", m_cnt, 1);
    chk("addr_after_first", m_addr, 1);
    send(OP_SUB, 1'b0, 5'd5, 5'd6, 5'd7, 12'd0, 1'b0);
    send(OP_NOR, 1'b0, 5'd10, 5'd11, 5'd12, 12'd0, 1'b1);

    // I-type session: ADDI, SRAI(last)
    do_start();
    send(OP_ADD, 1'b1, 5'd1, 5'd0, 5'd0, 12'd5, 1'b0);
    send(OP_SRA, 1'b1, 5'd2, 5'd3, 5'd0, 12'd4, 1'b1);

    // Unencodable requests, then a valid ADD at the same address
    do_start();
    send(OP_MUL, 1'b1, 5'd1, 5'd2, 5'd3, 12'd7, 1'b0);
    send(OP_MOV, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0, 1'b0);
    send(OP_ADD, 1'b0, 5'd4, 5'd5, 5'd6, 12'd0, 1'b1);

    // Unencodable request carrying last ends the session
    do_start();
    send(4'b1111, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0, 1'b1);

    // DEPTH=4 instance: six requests, no last -> stops after four writes
    sel = 1'b1; depth_m = 4;
    do_start();
    for (int i = 0; i < 6; i++)
      send(OP_XOR, 1'b0, 5'(i + 1), 5'(i + 2), 5'(i + 3), 12'd0, 1'b0);
    chk("full_state_idle", st_s, ST_IDLE);
    sel = 1'b0; depth_m = 64;

    // Asynchronous reset during WRITE
    do_start();
    opsel = OP_OR; is_imm = 1'b0; rd = 5'd9; rs1 = 5'd8; rs2 = 5'd7; last = 1'b0;
    v = 1'b1;
    @(posedge clk);
    #2;
    v = 1'b0;
    chk("we_before_reset", m_we, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", m_we, 0);
    chk("arst_ready", m_ready, 0);
    chk("arst_busy", m_busy, 0);
    chk("arst_addr", m_addr, 0);
    chk("arst_wdata", m_wdata, 0);
    chk("arst_count", m_cnt, 0);
    chk("arst_state", st_a, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    chk("restart_addr", m_addr, 0);
    send(OP_AND, 1'b1, 5'd3, 5'd4, 5'd0, 12'hABC, 1'b1);

    // Randomized sessions
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 10);
      do_start();
      for (int i = 0; i < n; i++)
        send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom), i == n - 1);
    end

    repeat (2) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the ID-stage control decode: accepts operation requests (Opsel code, register indices, optional immediate) and encodes them into 32-bit R-type or I-type instruction words.
- Encoded words are written sequentially into instruction memory through an address counter.
- Used by the bench and the boot path to load programs before the core runs.
- Request handshake is valid/ready. Completion and encode errors are reported as status outputs.

Parameters:
- DEPTH, 64, instruction memory depth in words; must be a power of 2, minimum 2.
- ADDR_W, $clog2(DEPTH), width of the word address.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session at address 0.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_opsel  in  4  Opsel code, using the same 4-bit ALU encoding as the control unit.
- req_is_imm  in  1  1 = I-type (opcode 0010011); 0 = R-type (opcode 0110011).
- req_rd, req_rs1, req_rs2  in  5 each  register indices; req_rs2 is ignored for I-type.
- req_imm  in  12  I-type immediate.
- req_last  in  1  marks the final request of the session.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  session active.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky unencodable-request flag.
- word_count  out  ADDR_W+1  words written in the current session.

Behaviour:
- Reset values (all outputs 0):
  - FSM = IDLE.
  - req_ready, imem_we, busy, done, err = 0.
  - imem_addr, imem_wdata, word_count = 0.
- FSM states are IDLE, ACCEPT, WRITE, FIN.
- IDLE:
  - start -> clear address, word_count and err; go to ACCEPT.
  - start is ignored in every other state.
- ACCEPT:
  - req_ready = 1, busy = 1.
  - On req_valid & req_ready, the request is captured and encoded into a registered word.
  - Unencodable request: err is set, nothing is written, the address does not advance, and the FSM stays in ACCEPT. If req_last is set on that request, go to FIN.
  - Encodable request: go to WRITE.
- WRITE:
  - imem_we = 1 for exactly one cycle, with imem_addr = current address and imem_wdata = encoded word.
  - Write latency is 1 cycle after the accepting edge. req_ready = 0.
  - At the end of the cycle, the address and word_count increment.
  - Go to FIN if the captured req_last = 1 or the address was DEPTH-1. This is the full condition: no wrap-around and no overwrite.
  - Otherwise return to ACCEPT.
- FIN:
  - done = 1 for one cycle, busy = 0.
  - Go to IDLE.
  - word_count and err hold until the next start.
- Encoding:
  - R-type word: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I-type word: {imm[11:0], rs1, funct3, rd, opcode}.
  - funct7 is a 7-bit value (0–3 used).
- R-type map, Opsel -> (funct7, funct3):
  - 0000 ADD -> (0, 0); 0001 SUB -> (0, 1); 1101 MUL -> (0, 2).
  - 0010 SLL -> (1, 0); 0011 SRL -> (1, 1); 0111 SLA -> (1, 2); 1000 SRA -> (1, 3).
  - 0100 SLT -> (2, 0); 0101 SGT -> (2, 1).
  - 0110 XOR -> (3, 0); 1001 AND -> (3, 1); 1010 OR -> (3, 2); 1011 NAND -> (3, 3); 1100 NOR -> (3, 4).
  - 1110 and 1111 are unencodable.
- I-type map, Opsel -> funct3:
  - ADD -> 0, SLT -> 1, AND -> 2, OR -> 3, XOR -> 4, SLL -> 5, SRL -> 6, SRA -> 7.
  - All other Opsel values are unencodable.
- Reset mid-session: asynchronous return to the reset state. A partially written program is not erased; memory contents are the memory's concern.

Decomposition:
- Shared package isa_pkg holds:
  - OPC_RTYPE = 7'b0110011 and OPC_ITYPE = 7'b0010011.
  - The Opsel code constants (OP_ADD ... OP_MOV).
  - The FSM state typedef.
  - The control unit imports the same Opsel constants.
- One combinational sub-module, instr_field_encoder:
  - Inputs: opsel, is_imm, rd, rs1, rs2, imm.
  - Outputs: word[31:0], valid_enc.
  - Keeps the map table separate from the sequencing logic.

Test Plan:
- start; R ADD rd=3 rs1=1 rs2=2, req_last=0 -> write addr 0, wdata 0x002081B3 one cycle after accept; word_count=1.
- R SUB rd=5 rs1=6 rs2=7, then R NOR rd=10 rs1=11 rs2=12 with req_last=1 -> addr 1 = 0x007312B3, addr 2 = 0x06C5C533; done pulses one cycle later; word_count=3; err=0.
- I ADDI rd=1 rs1=0 imm=5, then I SRAI rd=2 rs1=3 imm=4 -> 0x00500093 and 0x0041F113.
- Unencodable requests: I-type MUL (1101), then R-type opsel 1110 -> err=1, no imem_we, address unchanged. A following valid ADD is written at the same address.
- DEPTH=4, six back-to-back requests with no req_last -> four writes (addr 0–3), done after the fourth write; req_ready stays 0 afterwards.
- rst_n asserted low during WRITE -> imem_we and all other outputs immediately 0, FSM IDLE. A new start restarts at addr 0 with word_count=0.
